// File: rtl/mem_access.sv
// Memory-access stage: forwards write-back fields and performs at most one req/ack data-memory access.
// Optional sub-word (byte/half) accesses are enabled by defining MEM_SUBWORD_EN.
module mem_access (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    output logic        done,
    input  logic [1:0]  mselector,
    input  logic [2:0]  funct3,
    input  logic [2:0]  wselector_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] addr,
    input  logic [31:0] sdata,
    input  logic [4:0]  rd_in,
    output logic [2:0]  wselector,
    output logic [31:0] pc,
    output logic [4:0]  rd,
    output logic [31:0] data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE, WAIT, FIN} state_t;

    state_t      state_q;
    logic        done_q;
    logic        req_q;
    logic        we_q;
    logic        is_store_q;
    logic [31:0] addr_q;
    logic [31:0] maddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] data_q;
    logic [31:0] pc_q;
    logic [4:0]  rd_q;
    logic [2:0]  wsel_q;

    logic [31:0] st_wdata_d;
    logic [3:0]  st_wstrb_d;
    logic [31:0] ld_data_d;

`ifdef MEM_SUBWORD_EN
    logic [2:0]  funct3_q;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // funct3[1:0]: 00 byte, 01 half, 1x word; funct3[2] selects zero extension.
    always_comb begin
        st_wdata_d = sdata;
        st_wstrb_d = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_wdata_d = {4{sdata[7:0]}};
                st_wstrb_d = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                st_wdata_d = {2{sdata[15:0]}};
                st_wstrb_d = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte   = 8'(mem_rdata >> {addr_q[1:0], 3'b000});
        ld_half   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data_d = mem_rdata;
        case (funct3_q[1:0])
            2'b00:   ld_data_d = {{24{ld_byte[7] & ~funct3_q[2]}}, ld_byte};
            2'b01:   ld_data_d = {{16{ld_half[15] & ~funct3_q[2]}}, ld_half};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            funct3_q <= 3'b000;
        end else if (state_q == IDLE && enable) begin
            funct3_q <= funct3;
        end
    end
`else
    logic unused_funct3;

    assign unused_funct3 = ^funct3;
    assign st_wdata_d    = sdata;
    assign st_wstrb_d    = 4'b1111;
    assign ld_data_d     = mem_rdata;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            is_store_q <= 1'b0;
            addr_q     <= 32'h0;
            maddr_q    <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'b0000;
            data_q     <= 32'h0;
            pc_q       <= 32'h0;
            rd_q       <= 5'd0;
            wsel_q     <= 3'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        wsel_q     <= wselector_in;
                        pc_q       <= pc_in;
                        rd_q       <= rd_in;
                        addr_q     <= addr;
                        is_store_q <= mselector[0];
                        if (mselector[1]) begin
                            req_q   <= 1'b1;
                            we_q    <= mselector[0];
                            maddr_q <= {addr[31:2], 2'b00};
                            wdata_q <= st_wdata_d;
                            wstrb_q <= mselector[0] ? st_wstrb_d : 4'b0000;
                            state_q <= WAIT;
                        end else begin
                            data_q  <= addr;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        wstrb_q <= 4'b0000;
                        data_q  <= is_store_q ? addr_q : ld_data_d;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done      = done_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign data      = data_q;
    assign pc        = pc_q;
    assign rd        = rd_q;
    assign wselector = wsel_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed-vector bench for mem_access: table of transactions plus reset and enable-during-WAIT sequences.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic        done;
    logic [1:0]  mselector;
    logic [2:0]  funct3;
    logic [2:0]  wselector_in;
    logic [31:0] pc_in;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd_in;
    logic [2:0]  wselector;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_vec = 0;
    int n_err = 0;

    mem_access dut (
        .clk(clk), .rstn(rstn), .enable(enable), .done(done),
        .mselector(mselector), .funct3(funct3), .wselector_in(wselector_in),
        .pc_in(pc_in), .addr(addr), .sdata(sdata), .rd_in(rd_in),
        .wselector(wselector), .pc(pc), .rd(rd), .data(data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  msel;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [2:0]  wsel;
        logic [31:0] rdata;
        int          dly;
        logic [31:0] e_data;
        logic [31:0] e_maddr;
        logic        e_we;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        int          e_lat;
    } vec_t;

    vec_t vq[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] msel, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rdat, input int dly,
                       input logic [31:0] e_data, input logic [31:0] e_maddr, input logic e_we,
                       input logic [3:0] e_wstrb, input logic [31:0] e_wdata, input int e_lat);
        vec_t v;
        v.msel = msel; v.f3 = f3; v.addr = a; v.sdata = sd; v.rdata = rdat; v.dly = dly;
        v.pc = 32'h1000 + 32'(vq.size() * 4);
        v.rd = 5'(vq.size() + 3);
        v.wsel = 3'(vq.size() + 1);
        v.e_data = e_data; v.e_maddr = e_maddr; v.e_we = e_we; v.e_wstrb = e_wstrb;
        v.e_wdata = e_wdata; v.e_lat = e_lat;
        vq.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        int wcnt;
        int reqs;
        n_vec++;
        mselector = v.msel; funct3 = v.f3; addr = v.addr; sdata = v.sdata;
        pc_in = v.pc; rd_in = v.rd; wselector_in = v.wsel; enable = 1'b1;
        tick;
        enable = 1'b0;
        addr = 32'h5555_5555; sdata = 32'h6666_6666; rd_in = 5'd31; pc_in = 32'h0;
        cyc = 1; wcnt = 0; reqs = 0;
        if (v.msel[1]) begin
            chk("req_first", 32'(mem_req), 32'd1);
            chk("mem_we", 32'(mem_we), 32'(v.e_we));
            chk("mem_wstrb", 32'(mem_wstrb), 32'(v.e_wstrb));
            if (v.e_we) chk("mem_wdata", mem_wdata, v.e_wdata);
        end
        while (!done && cyc < 30) begin
            if (mem_req) begin
                reqs++;
                chk("mem_addr", mem_addr, v.e_maddr);
                if (wcnt == v.dly) begin
                    mem_ack = 1'b1;
                    mem_rdata = v.rdata;
                end else begin
                    wcnt++;
                end
            end
            tick;
            mem_ack = 1'b0;
            mem_rdata = 32'h0BAD_0BAD;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(v.e_lat));
        chk("done", 32'(done), 32'd1);
        chk("data", data, v.e_data);
        chk("pc", pc, v.pc);
        chk("rd", 32'(rd), 32'(v.rd));
        chk("wselector", 32'(wselector), 32'(v.wsel));
        chk("req_cycles", 32'(reqs), v.msel[1] ? 32'(v.dly + 1) : 32'd0);
        chk("req_at_done", 32'(mem_req), 32'd0);
        chk("we_at_done", 32'(mem_we), 32'd0);
        chk("wstrb_at_done", 32'(mem_wstrb), 32'd0);
        tick;
        chk("done_pulse", 32'(done), 32'd0);
        chk("data_hold", data, v.e_data);
    endtask

    initial begin
        int dones;
        rstn = 1'b0; enable = 1'b0; mselector = 2'b00; funct3 = 3'b010;
        wselector_in = 3'd0; pc_in = 32'h0; addr = 32'h0; sdata = 32'h0; rd_in = 5'd0;
        mem_rdata = 32'h0; mem_ack = 1'b0;

        // msel f3 addr sdata rdata dly | data maddr we wstrb wdata lat
        add(2'b00, 3'b010, 32'h0000_1234, 32'h0,         32'h0,         0, 32'h0000_1234, 32'h0,         1'b0, 4'h0, 32'h0,         1);
        add(2'b10, 3'b010, 32'h0000_0103, 32'h0,         32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0, 4'h0, 32'h0,         5);
        add(2'b11, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'h0,         0, 32'h0000_0204, 32'h0000_0204, 1'b1, 4'hF, 32'hCAFE_F00D, 2);
        add(2'b10, 3'b010, 32'h0000_0008, 32'h0,         32'h1234_5678, 0, 32'h1234_5678, 32'h0000_0008, 1'b0, 4'h0, 32'h0,         2);
        add(2'b11, 3'b010, 32'hFFFF_FFFE, 32'h0F0F_1234, 32'h0,         2, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 1'b1, 4'hF, 32'h0F0F_1234, 4);
        add(2'b01, 3'b010, 32'hA5A5_0001, 32'h1111_1111, 32'h0,         0, 32'hA5A5_0001, 32'h0,         1'b0, 4'h0, 32'h0,         1);
`ifdef MEM_SUBWORD_EN
        add(2'b10, 3'b000, 32'h0000_0002, 32'h0,         32'h0080_0000, 1, 32'hFFFF_FF80, 32'h0,         1'b0, 4'h0, 32'h0,         3);
        add(2'b10, 3'b100, 32'h0000_0002, 32'h0,         32'h0080_0000, 0, 32'h0000_0080, 32'h0,         1'b0, 4'h0, 32'h0,         2);
        add(2'b11, 3'b001, 32'h0000_0002, 32'h0000_ABCD, 32'h0,         0, 32'h0000_0002, 32'h0,         1'b1, 4'hC, 32'hABCD_ABCD, 2);
        add(2'b11, 3'b000, 32'h0000_0041, 32'h0000_005A, 32'h0,         1, 32'h0000_0041, 32'h0000_0040, 1'b1, 4'h2, 32'h5A5A_5A5A, 3);
        add(2'b10, 3'b001, 32'h0000_0003, 32'h0,         32'h8001_1234, 0, 32'hFFFF_8001, 32'h0,         1'b0, 4'h0, 32'h0,         2);
        add(2'b10, 3'b101, 32'h0000_0000, 32'h0,         32'h8001_F234, 0, 32'h0000_F234, 32'h0,         1'b0, 4'h0, 32'h0,         2);
`endif

        tick; tick;
        n_vec++;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_wsel", 32'(wselector), 32'd0);
        rstn = 1'b1;
        tick;

        foreach (vq[i]) run_vec(vq[i]);

        // enable while waiting for ack must be dropped
        n_vec++;
        mselector = 2'b10; funct3 = 3'b010; addr = 32'h0000_0300; rd_in = 5'd7;
        wselector_in = 3'b101; pc_in = 32'h0000_2000; enable = 1'b1;
        tick;
        enable = 1'b0;
        tick;
        mselector = 2'b00; addr = 32'h0000_0999; rd_in = 5'd9; wselector_in = 3'b001; enable = 1'b1;
        tick;
        enable = 1'b0;
        chk("busy_req", 32'(mem_req), 32'd1);
        chk("busy_maddr", mem_addr, 32'h0000_0300);
        mem_ack = 1'b1; mem_rdata = 32'h7777_0000;
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            tick;
            mem_ack = 1'b0;
            if (done) begin
                dones++;
                chk("busy_rd", 32'(rd), 32'd7);
                chk("busy_data", data, 32'h7777_0000);
                chk("busy_wsel", 32'(wselector), 32'b101);
            end
        end
        chk("busy_done_count", 32'(dones), 32'd1);

        // asynchronous reset while a request is outstanding
        n_vec++;
        mselector = 2'b11; addr = 32'h0000_0444; sdata = 32'h1357_9BDF; rd_in = 5'd12; enable = 1'b1;
        tick;
        enable = 1'b0;
        tick;
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        rstn = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_we", 32'(mem_we), 32'd0);
        chk("arst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("arst_rd", 32'(rd), 32'd0);
        chk("arst_data", data, 32'd0);
        tick;
        rstn = 1'b1;
        tick;
        mem_ack = 1'b1;
        dones = 0;
        for (int k = 0; k < 5; k++) begin
            tick;
            mem_ack = 1'b0;
            if (done) dones++;
            if (mem_req) dones++;
        end
        chk("stray_ack_done", 32'(dones), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the multi-cycle core, between execute and write-back. It takes one instruction per `enable` pulse, performs at most one data-memory transaction over a req/ack port, and forwards `wselector`, `pc`, `rd` and result `data` to the write-back stage. Completion is signalled with a one-cycle `done` pulse.

## Interface
- Parameters: none.
- `clk`  in  1  clock; all state updates on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  one-cycle start pulse; inputs valid this cycle.
- `done`  out  1  one-cycle pulse; outputs below valid from this cycle until next `done`.
- `mselector`  in  2  bit1 = memory access, bit0 = store (1) / load (0).
- `funct3`  in  3  access width/sign; used only with `MEM_SUBWORD_EN`.
- `wselector_in`  in  3  forwarded to `wselector`.
- `pc_in`  in  32  forwarded to `pc`.
- `addr`  in  32  byte address or ALU result.
- `sdata`  in  32  store data.
- `rd_in`  in  5  forwarded to `rd`.
- `wselector`  out  3  registered copy for write-back.
- `pc`  out  32  registered copy.
- `rd`  out  5  registered copy.
- `data`  out  32  load result, or `addr` for non-load.
- `mem_req`  out  1  request; held until ack.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word-aligned: `{addr[31:2],2'b00}`.
- `mem_wdata`  out  32  write data.
- `mem_wstrb`  out  4  byte lanes written; 4'b0000 on reads.
- `mem_rdata`  in  32  read data, valid when `mem_ack`=1.
- `mem_ack`  in  1  transaction complete this cycle.

## Operation
- States: IDLE, WAIT, FIN.
- IDLE + `enable`:
  - Latch `wselector_in`, `pc_in`, `rd_in`.
  - `mselector[1]`=0: `data`<=`addr`; go to FIN.
  - `mselector[1]`=1: drive `mem_req`=1, `mem_we`=`mselector[0]`, `mem_addr`, `mem_wdata`, `mem_wstrb`; go to WAIT.
- WAIT: request outputs stay stable. On `mem_ack`=1: drop `mem_req`/`mem_we`/`mem_wstrb`.
  - Load: `data`<=extracted `mem_rdata`.
  - Store: `data`<=`addr`.
  - Go to FIN.
- FIN: `done`<=1 for one cycle; return to IDLE.
- `enable` in WAIT or FIN is ignored; no queuing.
- `mem_ack` outside WAIT is ignored.
- Without `MEM_SUBWORD_EN`: word access only; `addr[1:0]` ignored; `mem_wstrb`=4'b1111 on stores; load `data`=`mem_rdata`.
- Reset (`rstn`=0, any state, async): state IDLE; `done`, `mem_req`, `mem_we`=0; `mem_wstrb`=0; `mem_addr`, `mem_wdata`, `data`, `pc`, `rd`, `wselector`=0. A transaction in flight is abandoned; a later `mem_ack` is ignored.

## Timing
- `enable` at cycle N, no access: FIN at N+1, `done` at N+1.
- Access: `mem_req` high from N+1. Ack may come the same cycle as the first request (M=N+1) or later. If ack is sampled at cycle M, FIN is at M+1 and `done` at M+1.
- Minimum access latency is `enable` to `done` = 2 cycles.
- `mem_req` falls at M+1.
- Outputs change only at the capture edge; they are stable while `done`=1 and afterwards.

## Configuration
- `MEM_SUBWORD_EN` defined: `funct3` selects width. Lane offset comes from `addr[1:0]`; halfwords use `addr[1]`; misaligned accesses use the aligned-down lane.
  - 000 = byte, signed.
  - 001 = half, signed.
  - 010 = word.
  - 100 = byte, unsigned.
  - 101 = half, unsigned.
  - Others = word.
  - Stores:
    - `mem_wdata` holds byte/half replicated across lanes.
    - `mem_wstrb` = 4'b0001<<`addr[1:0]` for bytes.
    - `mem_wstrb` = 4'b0011<<(2·`addr[1]`) for halves.
  - Loads: lane extracted, then sign- or zero-extended.
- Not defined: `funct3` ignored; all accesses are words, as above.

## Test plan
- Reset mid-WAIT: assert `rstn`=0 while `mem_req`=1 → `mem_req`=0 immediately. After release, a stray `mem_ack` produces no `done`.
- Non-access: `enable`, `mselector`=00, `addr`=0x1234, `rd_in`=5, `wselector_in`=3'b010 → `done` next cycle, `data`=0x1234, `rd`=5, `wselector`=3'b010, `mem_req` never high.
- Word load, ack delayed 3 cycles: `addr`=0x103, `mem_rdata`=0xDEADBEEF →
  - `mem_addr`=0x100 throughout WAIT.
  - `done` one cycle after ack, `data`=0xDEADBEEF.
- Store, ack same cycle as request: `sdata`=0xCAFEF00D → `mem_we`=1, `mem_wstrb`=4'b1111, `mem_req` high exactly 1 cycle, `done` 2 cycles after `enable`.
- `enable` during WAIT with different `rd_in` → ignored; outputs reflect the first instruction; exactly one `done`.
- `MEM_SUBWORD_EN`:
  - LB, `addr`=0x2, `mem_rdata`=0x00800000 → `data`=0xFFFFFF80.
  - LBU → `data`=0x00000080.
  - SH, `addr`=0x2, `sdata`=0xABCD → `mem_wstrb`=4'b1100, `mem_wdata`=0xABCDABCD.
